greater_than_bist: RTL and testbench
====================================

GREATER_THAN_BIST -- requirements
Module: greater_than_bist

Interface
REQ-001 Parameter WIDTH, default 2: operand width of the comparator under test.
REQ-002 Parameter SETTLE, default 1, legal range 1..15: clock cycles each vector is held before the DUT output is sampled.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  run request; sampled only in IDLE and DONE.
REQ-006 dut_gt  input  1  greater-than result returned by the comparator under test.
REQ-007 a  output  WIDTH  first operand driven to the comparator (DUT i1).
REQ-008 b  output  WIDTH  second operand driven to the comparator (DUT i0).
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  high in DONE when err_count == 0.
REQ-012 err_count  output  2*WIDTH+1  number of mismatching vectors in the current or last run.
REQ-013 fail_valid  output  1  at least one mismatch was captured in the current or last run.
REQ-014 fail_a, fail_b  output  WIDTH each  operands of the first mismatching vector.

Function
REQ-015 FSM states SHALL be IDLE, APPLY, CHECK and DONE; a 2*WIDTH-bit vector index idx SHALL hold the value {a,b}, so a is the outer loop and b the inner loop.
REQ-016 IDLE with start=1 SHALL, at that edge, clear err_count, fail_valid, fail_a, fail_b and idx, set busy=1 and enter APPLY.
REQ-017 APPLY SHALL hold a and b stable for exactly SETTLE cycles, counted by a settle counter, and then enter CHECK.
REQ-018 CHECK SHALL last one cycle; during it a and b are unchanged and dut_gt is compared against the unsigned golden result (a > b).
REQ-019 dut_gt SHALL be ignored in every state other than CHECK.
REQ-020 On a CHECK mismatch, err_count SHALL increment by 1 at the CHECK edge.
REQ-021 On a mismatch with fail_valid=0, fail_a and fail_b SHALL capture a and b, and fail_valid SHALL be set; later mismatches SHALL NOT overwrite the capture.
REQ-022 CHECK with idx below all-ones SHALL increment idx and return to APPLY.
REQ-023 CHECK with idx all-ones SHALL enter DONE, set busy=0 and set done=1; idx SHALL NOT wrap while busy.
REQ-024 Run length SHALL be exactly 2^(2*WIDTH)*(SETTLE+1) cycles from the start edge to the first cycle with done=1.
REQ-025 err_count SHALL be wide enough to hold 2^(2*WIDTH); no saturation logic is required.
REQ-026 pass SHALL equal done AND (err_count == 0), and SHALL be 0 outside DONE.
REQ-027 DONE SHALL hold done, pass, err_count and the fail_* outputs until start=1, which restarts the run exactly as in REQ-016.
REQ-028 start SHALL be ignored while in APPLY or CHECK.
REQ-029 a and b SHALL keep their last values in DONE and SHALL be 0 in IDLE.

Reset
REQ-030 reset_n=0 SHALL, without waiting for a clock edge, force state IDLE and drive all outputs and internal counters to 0.
REQ-031 This SHALL apply in every state, including mid-run; a run interrupted by reset SHALL NOT resume.
REQ-032 After reset_n rises, the first start SHALL begin a complete fresh run.

Verification
REQ-033 WIDTH=2, SETTLE=1, dut_gt modelled as combinational (a > b), 1-cycle start pulse -> busy for 32 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
REQ-034 dut_gt stuck at 0 -> err_count=6, pass=0, fail_valid=1, fail_a=1, fail_b=0.
REQ-035 dut_gt stuck at 1 -> err_count=10, pass=0, fail_a=0, fail_b=0.
REQ-036 reset_n pulsed low during vector idx=5 -> all outputs 0 immediately and state IDLE; a following start gives a full 32-cycle run with the correct result.
REQ-037 start held high throughout the run -> no restart mid-run; in DONE, start clears err_count and restarts from a=0, b=0.
REQ-038 SETTLE=3 with a correct DUT -> 64-cycle run, each vector held 4 cycles, pass=1.

Source files
------------

// File: rtl/greater_than_bist_if.sv
// Bus between the greater-than BIST controller and the comparator harness:
// run control, comparator operands/result and the run status outputs.
`timescale 1ns/1ps

interface greater_than_bist_if #(
  parameter int unsigned WIDTH = 2
) ();

  logic                 start;
  logic                 dut_gt;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2*WIDTH:0]     err_count;
  logic                 fail_valid;
  logic [WIDTH-1:0]     fail_a;
  logic [WIDTH-1:0]     fail_b;

  // The BIST controller sits on the slave side.
  modport slave (
    input  start,
    input  dut_gt,
    output a,
    output b,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_valid,
    output fail_a,
    output fail_b
  );

  // Whoever launches runs and models the comparator under test.
  modport master (
    output start,
    output dut_gt,
    input  a,
    input  b,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_valid,
    input  fail_a,
    input  fail_b
  );

endinterface

// File: rtl/greater_than_bist.sv
// Exhaustive BIST for a WIDTH-bit unsigned greater-than comparator: walks every
// {a,b} pair, holds each for SETTLE cycles, checks dut_gt and logs failures.
`timescale 1ns/1ps

module greater_than_bist #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  greater_than_bist_if.slave bus
);

  localparam int unsigned IDX_W = 2 * WIDTH;
  localparam int unsigned ERR_W = 2 * WIDTH + 1;
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

  localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       SETTLE_ONE = 4'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;

  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic             golden_gt;
  logic             mismatch;
  logic             last_vec;
  logic             settled;

  // idx is {a,b}, so a is the outer loop and b the inner loop.
  assign cur_a     = idx_q[IDX_W-1:WIDTH];
  assign cur_b     = idx_q[WIDTH-1:0];
  assign golden_gt = (cur_a > cur_b);
  assign mismatch  = (state_q == CHECK) && (bus.dut_gt != golden_gt);
  assign last_vec  = &idx_q;
  assign settled   = (settle_q == SETTLE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE keeps its results until a new run wipes them.
        if (bus.start) begin
          state_d      = APPLY;
          idx_d        = '0;
          settle_d     = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_a_d     = '0;
          fail_b_d     = '0;
        end
      end

      APPLY: begin
        if (settled) begin
          settle_d = '0;
          state_d  = CHECK;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
        end
      end

      CHECK: begin
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_a_d     = cur_a;
            fail_b_d     = cur_b;
          end
        end
        // Last vector ends the run with idx parked at all-ones.
        if (last_vec) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = APPLY;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.a          = (state_q == IDLE) ? '0 : cur_a;
  assign bus.b          = (state_q == IDLE) ? '0 : cur_b;
  assign bus.busy       = (state_q == APPLY) || (state_q == CHECK);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = (state_q == DONE) && (err_q == '0);
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_a     = fail_a_q;
  assign bus.fail_b     = fail_b_q;

endmodule

// File: tb/tb_greater_than_bist.sv
// Self-checking bench for greater_than_bist: two instances (SETTLE=1 and 3)
// with a behavioural comparator that can be correct or stuck at 0/1.
`timescale 1ns/1ps

module tb_greater_than_bist;

  localparam int W = 2;

  typedef struct {
    int err;
    bit fv;
    int fa;
    int fb;
    bit pass;
    int cycles;
  } exp_t;

  logic clk;
  logic reset_n;
  logic start_drv;
  bit   sel;
  int   mode;
  int   checks;
  int   failures;
  exp_t sb[$];

  greater_than_bist_if #(.WIDTH(W)) if1 ();
  greater_than_bist_if #(.WIDTH(W)) if3 ();

  greater_than_bist #(.WIDTH(W), .SETTLE(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if1)
  );

  greater_than_bist #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if3)
  );

  // Comparator under test: mode 0 correct, 1 stuck at 0, 2 stuck at 1.
  assign if1.dut_gt = (mode == 0) ? (if1.a > if1.b) : (mode == 2);
  assign if3.dut_gt = (mode == 0) ? (if3.a > if3.b) : (mode == 2);
  assign if1.start  = start_drv & ~sel;
  assign if3.start  = start_drv & sel;

  logic [W-1:0] obs_a, obs_b, obs_fa, obs_fb;
  logic [2*W:0] obs_err;
  logic         obs_busy, obs_done, obs_pass, obs_fv;

  assign obs_a    = sel ? if3.a          : if1.a;
  assign obs_b    = sel ? if3.b          : if1.b;
  assign obs_fa   = sel ? if3.fail_a     : if1.fail_a;
  assign obs_fb   = sel ? if3.fail_b     : if1.fail_b;
  assign obs_err  = sel ? if3.err_count  : if1.err_count;
  assign obs_busy = sel ? if3.busy       : if1.busy;
  assign obs_done = sel ? if3.done       : if1.done;
  assign obs_pass = sel ? if3.pass       : if1.pass;
  assign obs_fv   = sel ? if3.fail_valid : if1.fail_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result of a full run against the modelled comparator.
  task automatic expect_run(input int m, input int settle);
    exp_t e;
    bit   gt;
    e.err = 0; e.fv = 0; e.fa = 0; e.fb = 0;
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        gt = (m == 0) ? (ia > ib) : (m == 2);
        if (gt != (ia > ib)) begin
          e.err++;
          if (!e.fv) begin
            e.fv = 1; e.fa = ia; e.fb = ib;
          end
        end
      end
    end
    e.pass   = (e.err == 0);
    e.cycles = 16 * (settle + 1);
    sb.push_back(e);
  endtask

  // Called one cycle after the start edge; returns in the first DONE cycle.
  task automatic wait_run(input string tag, input int settle);
    int   cyc;
    int   vec_err;
    int   k;
    exp_t e;
    cyc = 0;
    vec_err = 0;
    while (obs_done !== 1'b1 && cyc < 400) begin
      k = cyc / (settle + 1);
      if (obs_busy !== 1'b1 || obs_a !== 2'(k >> 2) || obs_b !== 2'(k & 3))
        vec_err++;
      tick();
      cyc++;
    end
    checks++;
    if (cyc >= 400) begin
      failures++;
      $display("[TB] FAIL %s timeout: done=%b after %0d cycles, required done=1", tag, obs_done, cyc);
      return;
    end
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s scoreboard: queue empty, required one entry", tag);
      return;
    end
    e = sb.pop_front();
    if (vec_err !== 0) begin
      failures++;
      $display("[TB] FAIL %s vectors: %0d bad cycles, required 0", tag, vec_err);
    end
    checks++;
    if (cyc !== e.cycles) begin
      failures++;
      $display("[TB] FAIL %s run_length: got %0d, required %0d", tag, cyc, e.cycles);
    end
    checks++;
    if (obs_err !== e.err[2*W:0]) begin
      failures++;
      $display("[TB] FAIL %s err_count: got %0d, required %0d", tag, obs_err, e.err);
    end
    checks++;
    if (obs_pass !== e.pass || obs_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s pass/busy: got %b/%b, required %b/0", tag, obs_pass, obs_busy, e.pass);
    end
    checks++;
    if (obs_fv !== e.fv || obs_fa !== e.fa[W-1:0] || obs_fb !== e.fb[W-1:0]) begin
      failures++;
      $display("[TB] FAIL %s fail_capture: got v=%b a=%0d b=%0d, required v=%b a=%0d b=%0d",
               tag, obs_fv, obs_fa, obs_fb, e.fv, e.fa, e.fb);
    end
    checks++;
    if (obs_a !== 2'd3 || obs_b !== 2'd3) begin
      failures++;
      $display("[TB] FAIL %s done_operands: got a=%0d b=%0d, required 3/3", tag, obs_a, obs_b);
    end
  endtask

  task automatic launch(input int m, input int settle);
    start_drv = 1'b1;
    mode = m;
    expect_run(m, settle);
    tick();
    start_drv = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({obs_a, obs_b, obs_busy, obs_done, obs_pass, obs_err, obs_fv, obs_fa, obs_fb} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got a=%0d b=%0d busy=%b done=%b pass=%b err=%0d fv=%b, required all 0",
               obs_a, obs_b, obs_busy, obs_done, obs_pass, obs_err, obs_fv);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_correct_dut();
    launch(0, 1);
    wait_run("correct", 1);
    // Results must stay put in DONE while start is low.
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (obs_done !== 1'b1 || obs_pass !== 1'b1 || obs_err !== '0 || obs_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_hold: got done=%b pass=%b err=%0d busy=%b, required 1/1/0/0",
               obs_done, obs_pass, obs_err, obs_busy);
    end
  endtask

  task automatic test_stuck_low();
    launch(1, 1);
    wait_run("stuck0", 1);
  endtask

  task automatic test_stuck_high();
    launch(2, 1);
    wait_run("stuck1", 1);
  endtask

  task automatic test_reset_mid_run();
    launch(0, 1);
    for (int i = 0; i < 10; i++) tick();
    #3 reset_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if ({obs_a, obs_b, obs_busy, obs_done, obs_pass, obs_err, obs_fv, obs_fa, obs_fb} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset: got a=%0d b=%0d busy=%b err=%0d, required all 0",
               obs_a, obs_b, obs_busy, obs_err);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL no_resume: got busy=%b done=%b, required 0/0", obs_busy, obs_done);
    end
    launch(0, 1);
    wait_run("after_reset", 1);
  endtask

  task automatic test_start_held();
    start_drv = 1'b1;
    mode = 1;
    expect_run(1, 1);
    tick();
    wait_run("held", 1);
    expect_run(1, 1);
    tick();
    checks++;
    if (obs_err !== '0 || obs_a !== '0 || obs_b !== '0 || obs_busy !== 1'b1 || obs_fv !== 1'b0) begin
      failures++;
      $display("[TB] FAIL restart: got err=%0d a=%0d b=%0d busy=%b fv=%b, required 0/0/0/1/0",
               obs_err, obs_a, obs_b, obs_busy, obs_fv);
    end
    start_drv = 1'b0;
    wait_run("held_rerun", 1);
  endtask

  task automatic test_settle3();
    sel = 1'b1;
    #1;
    launch(0, 3);
    wait_run("settle3", 3);
    sel = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    sel       = 1'b0;
    mode      = 0;
    start_drv = 1'b0;
    reset_n   = 1'b1;
    test_reset();
    test_correct_dut();
    test_stuck_low();
    test_stuck_high();
    test_reset_mid_run();
    test_start_held();
    test_settle3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
